// File: rtl/uart_dbg_bridge.sv
// UART-to-bus debug command engine: halt/resume, single and burst bus access, overrun flag.
// Define DBG_RX_TIMEOUT_EN to build the inter-byte receive timeout.
module uart_dbg_bridge #(
  parameter int ADDR_W  = 16,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_active,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ack,
  output logic              cpu_halt,
  output logic              busy,
  output logic              err_overflow
);
  localparam int ADDR_BYTES = ADDR_W / 8;
  localparam int LEN_BYTES  = LEN_W / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_WDATA, S_WBUS, S_RBUS, S_TXWAIT, S_TXGAP
  } state_t;

  state_t            state_reg, state_next;
  logic [7:0]        hdr_cnt_reg, hdr_cnt_next;
  logic [2:0]        op_reg, op_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LEN_W-1:0]  cnt_reg, cnt_next;
  logic              exec_reg, exec_next;
  logic              halt_reg, halt_next;
  logic              hold_full_reg, hold_full_next;
  logic [7:0]        hold_data_reg, hold_data_next;
  logic              req_reg, req_next;
  logic              we_reg, we_next;
  logic [7:0]        wdata_reg, wdata_next;
  logic [7:0]        rbyte_reg, rbyte_next;
  logic              tx_start_reg, tx_start_next;
  logic [7:0]        tx_data_reg, tx_data_next;
  logic              ovf_reg, ovf_next;

  logic              byte_avail;
  logic [7:0]        byte_val;
  logic              receiving;
  logic              xfer_done;
  logic              start_data;
  logic              timeout_hit;
  logic [ADDR_W+7:0] addr_shift;
  logic [LEN_W+7:0]  cnt_shift;

  // A held byte is always older than one arriving now, so it is consumed first.
  assign byte_avail = hold_full_reg | rx_valid;
  assign byte_val   = hold_full_reg ? hold_data_reg : rx_data;
  assign receiving  = (state_reg == S_IDLE) || (state_reg == S_ADDR) ||
                      (state_reg == S_LEN)  || (state_reg == S_WDATA);

`ifdef DBG_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic            waiting;

  always_comb begin
    waiting     = (state_reg == S_ADDR) || (state_reg == S_LEN) || (state_reg == S_WDATA);
    to_cnt_next = to_cnt_reg;
    if (rx_valid || !waiting)
      to_cnt_next = '0;
    else if (to_cnt_reg != TO_W'(TIMEOUT))
      to_cnt_next = to_cnt_reg + 1'b1;
    timeout_hit = waiting && !byte_avail && (to_cnt_reg == TO_W'(TIMEOUT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_reg <= '0;
    else     to_cnt_reg <= to_cnt_next;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    hdr_cnt_next   = hdr_cnt_reg;
    op_next        = op_reg;
    addr_next      = addr_reg;
    cnt_next       = cnt_reg;
    exec_next      = exec_reg;
    halt_next      = halt_reg;
    hold_full_next = hold_full_reg;
    hold_data_next = hold_data_reg;
    req_next       = req_reg;
    we_next        = we_reg;
    wdata_next     = wdata_reg;
    rbyte_next     = rbyte_reg;
    tx_start_next  = 1'b0;
    tx_data_next   = tx_data_reg;
    ovf_next       = ovf_reg;
    xfer_done      = 1'b0;
    start_data     = 1'b0;
    addr_shift     = {addr_reg, byte_val};
    cnt_shift      = {cnt_reg, byte_val};

    if (receiving) begin
      if (hold_full_reg) begin
        hold_full_next = rx_valid;
        hold_data_next = rx_data;
      end
    end else if (rx_valid) begin
      if (hold_full_reg) begin
        ovf_next = 1'b1;
      end else begin
        hold_full_next = 1'b1;
        hold_data_next = rx_data;
      end
    end

    case (state_reg)
      S_IDLE: begin
        if (byte_avail) begin
          case (byte_val)
            8'h00: halt_next = 1'b1;
            8'h01: halt_next = 1'b0;
            8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07: begin
              op_next      = byte_val[2:0];
              hdr_cnt_next = '0;
              cnt_next     = '0;
              state_next   = S_ADDR;
            end
            8'h08: ovf_next = 1'b0;
            default: ;
          endcase
        end
      end
      S_ADDR: begin
        if (byte_avail) begin
          addr_next = addr_shift[ADDR_W-1:0];
          if (hdr_cnt_reg == 8'(ADDR_BYTES - 1)) begin
            hdr_cnt_next = '0;
            if (op_reg[2]) begin
              state_next = S_LEN;
            end else begin
              exec_next  = halt_reg;
              start_data = 1'b1;
            end
          end else begin
            hdr_cnt_next = hdr_cnt_reg + 1'b1;
          end
        end
      end
      S_LEN: begin
        if (byte_avail) begin
          cnt_next = cnt_shift[LEN_W-1:0];
          if (hdr_cnt_reg == 8'(LEN_BYTES - 1)) begin
            hdr_cnt_next = '0;
            exec_next    = halt_reg;
            start_data   = 1'b1;
          end else begin
            hdr_cnt_next = hdr_cnt_reg + 1'b1;
          end
        end
      end
      S_WDATA: begin
        if (byte_avail) begin
          wdata_next = byte_val;
          if (exec_reg) state_next = S_WBUS;
          else          xfer_done  = 1'b1;
        end
      end
      S_WBUS, S_RBUS: begin
        if (!req_reg) begin
          req_next = 1'b1;
          we_next  = (state_reg == S_WBUS);
        end else if (bus_ack) begin
          req_next = 1'b0;
          we_next  = 1'b0;
          if (state_reg == S_RBUS) begin
            rbyte_next = bus_rdata;
            state_next = S_TXWAIT;
          end else begin
            xfer_done = 1'b1;
          end
        end
      end
      S_TXWAIT: begin
        if (!tx_active) begin
          tx_start_next = 1'b1;
          tx_data_next  = rbyte_reg;
          state_next    = S_TXGAP;
        end
      end
      S_TXGAP: xfer_done = 1'b1;
      default: state_next = S_IDLE;
    endcase

    // Only opcodes 0x04/0x05 step the address; fixed bursts keep pointing at one data port.
    if (xfer_done) begin
      if (op_reg[2:1] == 2'b10) addr_next = addr_reg + 1'b1;
      if (cnt_reg == '0) begin
        state_next = S_IDLE;
      end else begin
        cnt_next   = cnt_reg - 1'b1;
        start_data = 1'b1;
      end
    end

    if (start_data) begin
      if (!op_reg[0]) begin
        state_next = S_WDATA;
      end else if (exec_next) begin
        state_next = S_RBUS;
      end else begin
        rbyte_next = 8'hFF;
        state_next = S_TXWAIT;
      end
    end

    if (timeout_hit) state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      hdr_cnt_reg   <= '0;
      op_reg        <= '0;
      addr_reg      <= '0;
      cnt_reg       <= '0;
      exec_reg      <= 1'b0;
      halt_reg      <= 1'b0;
      hold_full_reg <= 1'b0;
      hold_data_reg <= '0;
      req_reg       <= 1'b0;
      we_reg        <= 1'b0;
      wdata_reg     <= '0;
      rbyte_reg     <= '0;
      tx_start_reg  <= 1'b0;
      tx_data_reg   <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hdr_cnt_reg   <= hdr_cnt_next;
      op_reg        <= op_next;
      addr_reg      <= addr_next;
      cnt_reg       <= cnt_next;
      exec_reg      <= exec_next;
      halt_reg      <= halt_next;
      hold_full_reg <= hold_full_next;
      hold_data_reg <= hold_data_next;
      req_reg       <= req_next;
      we_reg        <= we_next;
      wdata_reg     <= wdata_next;
      rbyte_reg     <= rbyte_next;
      tx_start_reg  <= tx_start_next;
      tx_data_reg   <= tx_data_next;
      ovf_reg       <= ovf_next;
    end
  end

  assign tx_start     = tx_start_reg;
  assign tx_data      = tx_data_reg;
  assign bus_req      = req_reg;
  assign bus_we       = we_reg;
  assign bus_addr     = addr_reg;
  assign bus_wdata    = wdata_reg;
  assign cpu_halt     = halt_reg;
  assign busy         = (state_reg != S_IDLE);
  assign err_overflow = ovf_reg;
endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Scoreboard bench for uart_dbg_bridge: bus and UART responders pop expected transactions.
`timescale 1ns/1ps
module tb_uart_dbg_bridge;
  localparam int ADDR_W  = 16;
  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 50;
  localparam int TX_LEN  = 12;
  localparam int BUS_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_active = 1'b0;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_wdata;
  logic [7:0]        bus_rdata = 8'h00;
  logic              bus_ack = 1'b0;
  logic              cpu_halt;
  logic              busy;
  logic              err_overflow;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } bus_exp_t;

  bus_exp_t   exp_bus[$];
  logic [7:0] exp_tx[$];
  int n_checks = 0;
  int n_errors = 0;
  int rd_issue = 0;
  int rd_seen = 0;
  int req_cycles = 0;
  int tx_pulses = 0;
  int wait_cnt = 0;
  int tx_busy = 0;
  int byte_gap = 6;
  bit stall = 1'b0;

  uart_dbg_bridge #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_active(tx_active),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .cpu_halt(cpu_halt), .busy(busy),
    .err_overflow(err_overflow)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] rd_val(input int n);
    return 8'((n * 37) + 92);
  endfunction

  // Bus slave: acknowledges after BUS_LAT request cycles and checks against the scoreboard.
  initial begin
    bus_exp_t e;
    forever begin
      @(negedge clk);
      if (bus_req) req_cycles++;
      if (rst || bus_ack) begin
        bus_ack  = 1'b0;
        wait_cnt = 0;
      end else if (bus_req && !stall) begin
        wait_cnt++;
        if (wait_cnt >= BUS_LAT) begin
          n_checks++;
          if (exp_bus.size() == 0) begin
            n_errors++;
            $display("FAIL bus_unexpected: got we=%0b addr=%h data=%h, required no access",
                     bus_we, bus_addr, bus_wdata);
          end else begin
            e = exp_bus.pop_front();
            if (bus_we !== e.we || bus_addr !== e.addr || (e.we && bus_wdata !== e.data)) begin
              n_errors++;
              $display("FAIL bus_access: got we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                       bus_we, bus_addr, bus_wdata, e.we, e.addr, e.data);
            end
          end
          if (!bus_we) begin
            bus_rdata = rd_val(rd_seen);
            rd_seen++;
          end
          $display("bus %s addr=%h data=%h", bus_we ? "wr" : "rd", bus_addr,
                   bus_we ? bus_wdata : bus_rdata);
          bus_ack = 1'b1;
        end
      end
    end
  end

  // UART transmitter: busy for TX_LEN cycles per byte; bytes must start only when idle.
  initial begin
    logic [7:0] x;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        tx_pulses++;
        n_checks++;
        if (tx_active !== 1'b0) begin
          n_errors++;
          $display("FAIL tx_while_active: got tx_active=%0b at tx_start, required 0", tx_active);
        end
        n_checks++;
        if (exp_tx.size() == 0) begin
          n_errors++;
          $display("FAIL tx_unexpected: got byte %h, required none", tx_data);
        end else begin
          x = exp_tx.pop_front();
          if (tx_data !== x) begin
            n_errors++;
            $display("FAIL tx_data: got %h, required %h", tx_data, x);
          end
        end
        $display("uart tx data=%h", tx_data);
        tx_busy = TX_LEN;
      end else if (tx_busy > 0) begin
        tx_busy--;
      end
      tx_active = (tx_busy > 0);
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (byte_gap) @(posedge clk);
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
    exp_bus.push_back('{we: 1'b1, addr: a, data: d});
  endtask

  task automatic push_rd(input logic [15:0] a);
    exp_bus.push_back('{we: 1'b0, addr: a, data: 8'h00});
    exp_tx.push_back(rd_val(rd_issue));
    rd_issue++;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (!busy && !tx_active && exp_bus.size() == 0 && exp_tx.size() == 0) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL %s_drain: got busy=%0b bus_left=%0d tx_left=%0d, required idle and empty",
               tag, busy, exp_bus.size(), exp_tx.size());
    end
  endtask

  task automatic wait_bus_req(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus_req) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s_req: got no bus_req within bound, required bus_req=1", tag);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cpu_halt, tx_start, bus_req, busy, err_overflow} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got halt/tx/req/busy/ovf=%b, required 00000",
               {cpu_halt, tx_start, bus_req, busy, err_overflow});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_halt_timing;
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    n_checks++;
    if (cpu_halt !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_early: got cpu_halt=%0b in opcode cycle, required 0", cpu_halt);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    n_checks++;
    if (cpu_halt !== 1'b1) begin
      n_errors++;
      $display("FAIL halt_set: got cpu_halt=%0b one cycle after opcode, required 1", cpu_halt);
    end
    repeat (byte_gap) @(posedge clk);
  endtask

  task automatic test_single;
    push_wr(16'h2006, 8'h3F);
    send_byte(8'h02); send_byte(8'h20); send_byte(8'h06); send_byte(8'h3F);
    push_rd(16'h2006);
    send_byte(8'h03); send_byte(8'h20); send_byte(8'h06);
    wait_idle("single");
  endtask

  task automatic test_burst_wrap;
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 8'h11 * 8'(i + 1);
      push_wr(16'(32'hFFFE + i), d);
    end
    send_byte(8'h04); send_byte(8'hFF); send_byte(8'hFE); send_byte(8'h03);
    for (int i = 0; i < 4; i++) begin
      d = 8'h11 * 8'(i + 1);
      send_byte(d);
    end
    wait_idle("burst_wrap");
  endtask

  task automatic test_fixed_read;
    int p0;
    int r0;
    p0 = tx_pulses;
    r0 = rd_seen;
    for (int i = 0; i < 3; i++) push_rd(16'h2007);
    send_byte(8'h07); send_byte(8'h20); send_byte(8'h07); send_byte(8'h02);
    wait_idle("fixed_read");
    n_checks++;
    if (tx_pulses - p0 !== 3 || rd_seen - r0 !== 3) begin
      n_errors++;
      $display("FAIL fixed_read_count: got %0d tx pulses %0d reads, required 3 and 3",
               tx_pulses - p0, rd_seen - r0);
    end
  endtask

  task automatic test_not_halted_overflow;
    int q0;
    send_byte(8'h01);
    n_checks++;
    if (cpu_halt !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_clear: got cpu_halt=%0b, required 0", cpu_halt);
    end
    q0 = req_cycles;
    exp_tx.push_back(8'hFF);
    exp_tx.push_back(8'hFF);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h10); send_byte(8'h01);
    wait_idle("not_halted");
    n_checks++;
    if (req_cycles !== q0) begin
      n_errors++;
      $display("FAIL not_halted_bus: got %0d bus_req cycles, required 0", req_cycles - q0);
    end
    send_byte(8'h00);
    stall = 1'b1;
    push_rd(16'h2000);
    send_byte(8'h03); send_byte(8'h20); send_byte(8'h00);
    wait_bus_req("overflow");
    byte_gap = 1;
    send_byte(8'h55);
    send_byte(8'h66);
    byte_gap = 6;
    @(negedge clk);
    n_checks++;
    if (err_overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL overflow_set: got err_overflow=%0b, required 1", err_overflow);
    end
    stall = 1'b0;
    wait_idle("overflow");
    n_checks++;
    if (err_overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL overflow_sticky: got err_overflow=%0b, required 1", err_overflow);
    end
    send_byte(8'h08);
    n_checks++;
    if (err_overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL overflow_clear: got err_overflow=%0b, required 0", err_overflow);
    end
  endtask

  task automatic test_reset_mid_burst;
    stall = 1'b1;
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h10); send_byte(8'h03); send_byte(8'h11);
    wait_bus_req("mid_burst");
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({cpu_halt, tx_start, bus_req, busy, err_overflow} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_mid_burst: got halt/tx/req/busy/ovf=%b, required 00000",
               {cpu_halt, tx_start, bus_req, busy, err_overflow});
    end
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    stall = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || bus_req !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: got busy=%0b bus_req=%0b, required 0 0", busy, bus_req);
    end
    test_halt_timing();
    push_rd(16'h0040);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h40);
    wait_idle("after_reset");
  endtask

`ifdef DBG_RX_TIMEOUT_EN
  task automatic test_timeout;
    send_byte(8'h02); send_byte(8'h20);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_pending: got busy=%0b mid-header, required 1", busy);
    end
    repeat (60) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_abort: got busy=%0b after idle gap, required 0", busy);
    end
    push_rd(16'h0000);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
    wait_idle("timeout");
  endtask
`endif

  initial begin
    test_reset();
    test_halt_timing();
    test_single();
    test_burst_wrap();
    test_fixed_read();
    test_not_halted_overflow();
    test_reset_mid_burst();
`ifdef DBG_RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_dbg_bridge.md
Name: uart_dbg_bridge

Overview:
- Parametrised UART-to-bus debug command engine; successor to the fixed four-command (halt/resume/write/read) host interface of the PPU/memory/VGA top level.
- Sits between the uart_rx / UART_TX byte pipes and the system memory bus. Holds the CPU halted on request.
- Adds configurable address width, burst read/write with a length field, a fixed-address burst mode (for data ports such as $2007/$2004), an input overrun flag and an optional receive timeout.

Parameters:
- ADDR_W, 16, bus address width; multiple of 8; address is sent as ADDR_W/8 bytes, MSB first.
- LEN_W, 8, burst length field width; multiple of 8; transfer count = LEN+1, so the maximum is 2^LEN_W.
- TIMEOUT, 100000, inter-byte timeout in clk cycles (used only with the optional feature).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous reset, active-high.
- rx_valid, in, 1, one-cycle strobe: rx_data holds a received byte.
- rx_data, in, 8, received byte.
- tx_start, out, 1, one-cycle pulse to launch a UART byte.
- tx_data, out, 8, byte to transmit; valid with tx_start.
- tx_active, in, 1, transmitter busy.
- bus_req, out, 1, bus request; held until bus_ack.
- bus_we, out, 1, 1 = write, 0 = read; valid with bus_req.
- bus_addr, out, ADDR_W, access address.
- bus_wdata, out, 8, write data.
- bus_rdata, in, 8, read data; sampled in the bus_ack cycle.
- bus_ack, in, 1, one-cycle access completion.
- cpu_halt, out, 1, CPU halt request; bus commands execute only while this is high.
- busy, out, 1, high whenever the FSM is not in IDLE.
- err_overflow, out, 1, sticky input-overrun flag; cleared by reset or by opcode 0x08.

Behaviour:
- Reset: all outputs are 0 (cpu_halt=0, tx_start=0, bus_req=0, busy=0, err_overflow=0). The FSM goes to IDLE and the hold register is emptied. Reset mid-transaction aborts it immediately; an outstanding bus_ack is ignored.
- Opcodes, taken in IDLE:
  - 0x00: set cpu_halt.
  - 0x01: clear cpu_halt.
  - 0x02: single write: ADDR, DATA.
  - 0x03: single read: ADDR; replies with 1 byte.
  - 0x04: burst write, incrementing address: ADDR, LEN, DATA x (LEN+1).
  - 0x05: burst read, incrementing address: ADDR, LEN; replies with LEN+1 bytes.
  - 0x06: burst write, fixed address.
  - 0x07: burst read, fixed address.
  - 0x08: clear err_overflow.
  - Other values are ignored; the FSM stays in IDLE.
- Halt timing: 0x00/0x01 take effect on the cycle after the opcode's rx_valid.
- FSM states: IDLE -> ADDR (ADDR_W/8 bytes) -> [LEN (LEN_W/8 bytes) for 0x04-0x07] -> WDATA -> WBUS -> WDATA ... or RBUS -> TXWAIT -> RBUS ... -> IDLE once the count is exhausted.
- Write path (WDATA -> WBUS): bus_req=1, bus_we=1 until bus_ack.
- Read path:
  - RBUS: bus_req=1, bus_we=0 until bus_ack; the FSM latches bus_rdata.
  - TXWAIT: waits for tx_active=0, pulses tx_start for 1 cycle, then waits one cycle before rechecking tx_active.
- Bus latency: bus_req rises the cycle after entry to WBUS/RBUS. The request drops in the cycle after bus_ack.
- Address arithmetic: increment modes add 1 modulo 2^ADDR_W after each access, so 0xFFFF wraps to 0x0000 at ADDR_W=16. Fixed modes never change bus_addr.
- Not halted: if cpu_halt=0 when the command's last header byte arrives, no bus cycles are issued.
  - Write data bytes are still consumed and discarded.
  - Reads reply with 0xFF per byte.
- Input hold register:
  - rx_valid in WBUS, RBUS or TXWAIT loads a 1-deep hold register, which is consumed on the next byte-receiving state.
  - A second byte arriving while the hold register is full is dropped and sets err_overflow.
- A read reply's bytes are never reordered with a later command's reply.

Optional Feature:
- Macro: DBG_RX_TIMEOUT_EN.
- Defined: a counter resets on every rx_valid. If it reaches TIMEOUT while the FSM is in ADDR, LEN or WDATA, the FSM returns to IDLE and the partial command is discarded; bus writes already completed remain. In-flight bus and TX phases are unaffected.
- Undefined: the counter is not built and the FSM waits indefinitely for bytes.

Test Plan:
- Reset with rst=1 mid-burst, then release -> all outputs 0, busy=0; next command 0x00 gives cpu_halt=1 one cycle after its byte.
- 0x00; 0x02 20 06 3F; 0x03 20 06 -> one bus write at addr 0x2006 with data 0x3F, then one bus read of 0x2006 with one UART byte equal to bus_rdata.
- 0x00; 0x04 FF FE 03 then 11 22 33 44 -> writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001 with data 11, 22, 33, 44 (wrap check).
- 0x00; 0x07 20 07 02 -> three reads, all at 0x2007, and exactly three tx_start pulses, each issued only after tx_active=0.
- cpu_halt=0; 0x05 00 10 01 -> zero bus_req cycles; replies FF FF. Then inject 2 extra bytes during a stalled bus_ack -> err_overflow=1; 0x08 clears it.
- DBG_RX_TIMEOUT_EN with TIMEOUT=50: send 0x02 20 then idle 60 cycles -> busy=0; a following 0x03 00 00 executes normally.
